demux4_buf: RTL

//   Registered 1-to-4 distributor: the write-side counterpart of the 4:1 datapath mux.

---
 rtl/demux4_buf_pkg.sv | 26 ++
 rtl/demux4_buf_if.sv | 29 ++
 rtl/demux4_buf_slot.sv | 39 +++
 rtl/demux4_buf.sv | 54 +++++
 4 files changed

// File: rtl/demux4_buf_pkg.sv
// Shared constants for the 1-to-4 write distributor: default width, channel count
// and the select encodings also used by the 4:1 mux side.
package demux4_buf_pkg;

   localparam int DATA_W = 16;
   localparam int N_CH   = 4;

   localparam logic [1:0] SEL_CH0 = 2'd0;
   localparam logic [1:0] SEL_CH1 = 2'd1;
   localparam logic [1:0] SEL_CH2 = 2'd2;
   localparam logic [1:0] SEL_CH3 = 2'd3;

   // One-hot channel mask for a select value; unknown selects map to no channel.
   function automatic logic [N_CH-1:0] sel_decode(input logic [1:0] sel);
      logic [N_CH-1:0] mask;
      case (sel)
         SEL_CH0: mask = 4'b0001;
         SEL_CH1: mask = 4'b0010;
         SEL_CH2: mask = 4'b0100;
         SEL_CH3: mask = 4'b1000;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/demux4_buf_if.sv
// Producer/consumer bundle of the distributor. Handshake: a word moves on a side
// whenever valid and ready are both high at a rising clock edge.
interface demux4_buf_if import demux4_buf_pkg::*; #(
   parameter int WIDTH = DATA_W
);

   logic [WIDTH-1:0] d;
   logic [1:0]       s;
   logic             bcast;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] y0;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] y2;
   logic [WIDTH-1:0] y3;
   logic [N_CH-1:0]  out_valid;
   logic [N_CH-1:0]  out_ready;

   modport master (
      output d, s, bcast, in_valid, out_ready,
      input  in_ready, y0, y1, y2, y3, out_valid
   );

   modport slave (
      input  d, s, bcast, in_valid, out_ready,
      output in_ready, y0, y1, y2, y3, out_valid
   );

endinterface

// File: rtl/demux4_buf_slot.sv
// One buffered output channel: a data register plus a valid flag. The slot is
// free when empty or being drained this cycle, so drain and refill can share an edge.
module demux_slot import demux4_buf_pkg::*; #(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_y,
   output logic             o_valid,
   output logic             o_free
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;

   // Refill has priority over drain; data is never cleared by a drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_d;
         r_valid <= 1'b1;
      end else if (r_valid && i_out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_y     = r_data;
   assign o_valid = r_valid;
   assign o_free  = ~r_valid | i_out_ready;

   a_stall_holds : assert property (@(posedge clk) disable iff (!reset_n)
      (r_valid && !i_out_ready) |=> (r_valid && $stable(r_data)));

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 distributor: steers one word to a selected channel, or to all
// four when broadcasting, each channel holding a single handshaked entry.
module demux4_buf import demux4_buf_pkg::*; #(
   parameter int WIDTH = DATA_W
) (
   input logic         clk,
   input logic         reset_n,
   demux4_buf_if.slave bus
);

   logic [N_CH-1:0]  w_free;
   logic [N_CH-1:0]  w_valid;
   logic [N_CH-1:0]  w_target;
   logic [N_CH-1:0]  w_load;
   logic [WIDTH-1:0] w_y [N_CH];
   logic             w_in_ready;
   logic             w_accept;

   always_comb begin
      w_target = sel_decode(bus.s);
      if (bus.bcast) begin
         w_target = {N_CH{1'b1}};
      end
   end

   // Broadcast is all-or-nothing; in_ready never looks at in_valid.
   assign w_in_ready = reset_n & (bus.bcast ? (&w_free) : (|(w_target & w_free)));
   assign w_accept   = bus.in_valid & w_in_ready;
   assign w_load     = w_target & {N_CH{w_accept}};

   for (genvar g = 0; g < N_CH; g++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk         (clk),
         .reset_n     (reset_n),
         .i_load      (w_load[g]),
         .i_d         (bus.d),
         .i_out_ready (bus.out_ready[g]),
         .o_y         (w_y[g]),
         .o_valid     (w_valid[g]),
         .o_free      (w_free[g])
      );
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_valid;
   assign bus.y0        = w_y[0];
   assign bus.y1        = w_y[1];
   assign bus.y2        = w_y[2];
   assign bus.y3        = w_y[3];

   a_load_only_free : assert property (@(posedge clk) disable iff (!reset_n)
      (w_load & ~w_free) == '0);

endmodule
